button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Upstream front-end for the dice / traffic-light selector stage.
- Takes the raw, asynchronous, bouncing push-button and produces a clean debounced level, which drives the selector stage's `button` input.
- Also produces single-cycle press events.
- Also produces a `sel` output that toggles on every long press, so one physical button both rolls the dice and switches the displayed source.

Parameters:
- DEBOUNCE_CYCLES, 1000, consecutive synchronised cycles of disagreement needed before the debounced level changes; must be >= 1.
- LONG_PRESS_CYCLES, 50000, cycles the debounced level must stay high (counted from the rising edge) to register a long press; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- button_raw  input  1  raw asynchronous push-button, may bounce.
- button  output  1  debounced level; feeds the selector stage's `button`.
- press_pulse  output  1  one-cycle pulse on the debounced rising edge.
- short_press  output  1  one-cycle pulse on release when no long press fired.
- long_press  output  1  one-cycle pulse when the hold reaches LONG_PRESS_CYCLES.
- sel  output  1  source select, toggles on each long_press; feeds the selector stage's `sel`.

Behaviour:
- Reset (rst=1 at a clock edge): synchroniser flops, debounce counter, hold counter, button, sel, and all pulses go to 0; FSM goes to IDLE. Reset mid-press discards the press: no pulses, and sel returns to 0.
- Synchroniser: 2-flop chain on button_raw giving btn_s; 2 cycles of latency.
- Debounce counter and level update:
  - The counter increments each cycle that btn_s != button, and clears to 0 on any cycle that btn_s == button.
  - When the counter would reach DEBOUNCE_CYCLES, button takes the value of btn_s on that edge and the counter clears.
  - Total latency from a clean raw edge to the button change is 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes button.
- Counter widths are $clog2(param+1); counters saturate and never wrap.
- FSM states: IDLE, PRESSED, HELD.
  - IDLE: on the debounced rising edge (button 0 to 1), go to PRESSED, assert press_pulse for exactly that cycle, and clear the hold counter.
  - PRESSED, hold counter:
    - The hold counter increments each cycle.
    - The first PRESSED cycle counts as 1.
    - When the counter equals LONG_PRESS_CYCLES, assert long_press for one cycle, toggle sel on the same edge, and go to HELD.
  - PRESSED, release: if button falls first, assert short_press for one cycle and go to IDLE.
  - HELD: hold counter stops. On button falling, go to IDLE with no pulse. Only one long_press per press, however long it is held.
  - Simultaneous events: if button falls in the same cycle the hold counter reaches LONG_PRESS_CYCLES, the release wins: short_press fires, no long_press, sel unchanged.
- Pulse timing:
  - All pulses are registered, assert on the clock edge where the state transition happens, and deassert on the next edge.
  - press_pulse and short_press are never asserted together.
- sel holds its value indefinitely between long presses.

Decomposition:
- No shared package needed; both parameters are local.
- Shared state encoding IDLE/PRESSED/HELD as localparams in the module.
- One natural sub-module: debounce_sync, holding the 2-flop synchroniser plus the debounce counter, with ports clk, rst, din, dout and parameter DEBOUNCE_CYCLES.
- Keep the FSM and hold counter in the top of this block.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10):
- Reset behaviour: assert rst for 3 cycles with button_raw=1 -> all outputs 0 throughout, and button stays 0 until 6 cycles after rst falls.
- Bounce rejection: button_raw toggles 1,0,1,0 with each level held 2 cycles, then stays 0 -> button, press_pulse, and sel remain 0.
- Short press: button_raw high for 8 cycles, then low -> press_pulse exactly 6 cycles after the rising edge; short_press once, 6 cycles after the falling edge; sel stays 0.
- Long press: button_raw high for 30 cycles -> press_pulse, then long_press 9 cycles later with sel going 0 to 1 on the same edge; no short_press on release. A second long press returns sel to 0.
- Boundary: hold exactly long enough that the debounced fall lands on hold count 10 -> short_press fires, long_press does not, sel unchanged. With the fall one cycle later -> long_press fires, then IDLE with no short_press.
- Reset mid-press: rst in HELD with sel=1 -> sel=0 and state IDLE. Releasing and re-pressing afterwards yields a normal press_pulse.

Source files
------------

// File: rtl/button_conditioner_debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_sync
//  Purpose  : Two-flop synchroniser followed by a disagreement counter that
//             only lets the output level follow the synchronised input after
//             DEBOUNCE_CYCLES consecutive cycles of disagreement.
//  Revision : 1.0  initial release
// ============================================================================
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    // Value dout takes on the next rising edge, so a consumer can act on the
    // same edge as the level change.
    output logic dout_next
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_differ;
    logic               w_expire;

    // The counter already holds DEBOUNCE_CYCLES-1 disagreements, so this
    // cycle's disagreement completes the run and the level flips.
    assign w_differ  = (r_sync2 != r_level);
    assign w_expire  = w_differ && (r_cnt >= c_CNT_LAST);
    assign dout      = r_level;
    assign dout_next = w_expire ? r_sync2 : r_level;

    // Two-stage synchroniser for the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreement; any agreement restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (!w_differ) begin
            r_cnt   <= '0;
        end else if (w_expire) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Debounces a raw push-button and classifies each press as short
//             or long. Emits single-cycle press/short/long pulses and a
//             source-select level that toggles on every long press.
//  Revision : 1.0  initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int LONG_PRESS_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic button,
    output logic press_pulse,
    output logic short_press,
    output logic long_press,
    output logic sel
);

    localparam int                  c_HOLD_W     = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int                  c_HOLD_IW    = c_HOLD_W + 1;
    localparam logic [c_HOLD_IW-1:0] c_HOLD_LIMIT = c_HOLD_IW'(LONG_PRESS_CYCLES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_FIRST = c_HOLD_W'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_PRESSED = 2'd1;
    localparam logic [1:0] c_HELD    = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [c_HOLD_W-1:0]  r_hold;
    logic [c_HOLD_W-1:0]  w_hold_next;
    logic [c_HOLD_IW-1:0] w_hold_inc;
    logic                 w_btn;
    logic                 w_btn_next;
    logic                 r_press;
    logic                 r_short;
    logic                 r_long;
    logic                 r_sel;
    logic                 w_press;
    logic                 w_short;
    logic                 w_long;
    logic                 w_sel;

    debounce_sync #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_sync (
        .clk       (clk),
        .rst       (rst),
        .din       (button_raw),
        .dout      (w_btn),
        .dout_next (w_btn_next)
    );

    // r_hold is the number of PRESSED cycles including the current one, so
    // w_hold_inc is the count the hold reaches at the coming edge.
    assign w_hold_inc  = {1'b0, r_hold} + c_HOLD_IW'(1);

    assign button      = w_btn;
    assign press_pulse = r_press;
    assign short_press = r_short;
    assign long_press  = r_long;
    assign sel         = r_sel;

    // State, hold counter, pulses and select all update on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_hold  <= '0;
            r_press <= 1'b0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
            r_press <= w_press;
            r_short <= w_short;
            r_long  <= w_long;
            r_sel   <= w_sel;
        end
    end

    // Next state; a release in PRESSED beats a hold reaching the limit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_btn_next && !w_btn) begin
                    w_state_next = c_PRESSED;
                end
            end
            c_PRESSED: begin
                if (!w_btn_next) begin
                    w_state_next = c_IDLE;
                end else if (w_hold_inc >= c_HOLD_LIMIT) begin
                    w_state_next = c_HELD;
                end
            end
            c_HELD: begin
                if (!w_btn_next) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Pulse, select and hold-count values to load on the coming edge.
    always_comb begin
        w_press     = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_sel       = r_sel;
        w_hold_next = r_hold;
        case (r_state)
            c_IDLE: begin
                w_hold_next = '0;
                if (w_state_next == c_PRESSED) begin
                    w_press     = 1'b1;
                    w_hold_next = c_HOLD_FIRST;
                end
            end
            c_PRESSED: begin
                if (w_state_next == c_IDLE) begin
                    w_short = 1'b1;
                end else if (w_state_next == c_HELD) begin
                    w_long  = 1'b1;
                    w_sel   = ~r_sel;
                end else begin
                    // Below the limit here, so the count fits without wrapping.
                    w_hold_next = w_hold_inc[c_HOLD_W-1:0];
                end
            end
            default: begin
                // HELD: hold counter frozen until release.
                w_hold_next = r_hold;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Self-checking bench for button_conditioner with a cycle-level
//             reference model built from press/release event arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_button_conditioner;

    localparam int D = 4;
    localparam int L = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button_raw = 1'b0;
    logic button;
    logic press_pulse;
    logic short_press;
    logic long_press;
    logic sel;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int   t = 0;
    logic samp[$];
    logic dq[$];
    logic m_button = 1'b0;
    logic m_press  = 1'b0;
    logic m_short  = 1'b0;
    logic m_long   = 1'b0;
    logic m_sel    = 1'b0;
    int   press_at = 0;
    logic active    = 1'b0;
    logic long_done = 1'b0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button_raw  (button_raw),
        .button      (button),
        .press_pulse (press_pulse),
        .short_press (short_press),
        .long_press  (long_press),
        .sel         (sel)
    );

    function automatic logic [4:0] dut_vec();
        return {button, press_pulse, short_press, long_press, sel};
    endfunction

    function automatic logic [4:0] exp_vec();
        return {m_button, m_press, m_short, m_long, m_sel};
    endfunction

    // Advance the model by one clock edge given the inputs sampled there.
    // The level follows raw two samples late once the last D delayed samples
    // all disagree with it; pulses derive from the press start time.
    function automatic void model_step(input logic raw, input logic r);
        logic bs;
        logic prev;
        logic flip;
        t++;
        m_press = 1'b0;
        m_short = 1'b0;
        m_long  = 1'b0;
        if (r) begin
            samp.delete();
            dq.delete();
            m_button  = 1'b0;
            m_sel     = 1'b0;
            active    = 1'b0;
            long_done = 1'b0;
            return;
        end
        bs = (samp.size() == 2) ? samp[0] : 1'b0;
        samp.push_back(raw);
        if (samp.size() > 2) void'(samp.pop_front());
        dq.push_back(bs);
        if (dq.size() > D) void'(dq.pop_front());
        flip = (dq.size() == D);
        foreach (dq[i]) if (dq[i] == m_button) flip = 1'b0;
        prev = m_button;
        if (flip) begin
            m_button = ~m_button;
            dq.delete();
        end
        if (!prev && m_button) begin
            m_press   = 1'b1;
            press_at  = t;
            active    = 1'b1;
            long_done = 1'b0;
        end else if (active && !m_button) begin
            m_short = ~long_done;
            active  = 1'b0;
        end else if (active && !long_done && (t - press_at + 1 == L)) begin
            m_long    = 1'b1;
            long_done = 1'b1;
            m_sel     = ~m_sel;
        end
    endfunction

    task automatic tick(input logic raw, input logic r);
        button_raw = raw;
        rst        = r;
        @(posedge clk);
        model_step(raw, r);
        #1;
    endtask

    // Raw high for ticks 1..hi, low afterwards, n ticks total; records event
    // positions and how many cycles disagreed with the model.
    task automatic run_press(input int hi, input int n,
                             output int p_at, output int s_at, output int l_at,
                             output int p_cnt, output int s_cnt, output int l_cnt,
                             output int diffs);
        p_at = -1; s_at = -1; l_at = -1;
        p_cnt = 0; s_cnt = 0; l_cnt = 0; diffs = 0;
        for (int k = 1; k <= n; k++) begin
            tick(k <= hi, 1'b0);
            if (dut_vec() !== exp_vec()) diffs++;
            if (press_pulse === 1'b1) begin p_cnt++; if (p_at < 0) p_at = k; end
            if (short_press === 1'b1) begin s_cnt++; if (s_at < 0) s_at = k; end
            if (long_press  === 1'b1) begin l_cnt++; if (l_at < 0) l_at = k; end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1);
            n_checks++;
            if (dut_vec() !== 5'b0)
                $display("FAIL reset_outputs cyc %0d: got %b want 00000", k, dut_vec());
            else n_pass++;
        end
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0);
            n_checks++;
            if (button !== ((k >= 6) ? 1'b1 : 1'b0))
                $display("FAIL reset_release button cyc %0d: got %b want %b", k, button, (k >= 6));
            else n_pass++;
        end
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 1'b0);
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL reset_settle cyc %0d: got %b want %b", k, dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        pat = 8'b00110011;
        for (int k = 0; k < 20; k++) begin
            tick((k < 8) ? pat[k] : 1'b0, 1'b0);
            n_checks++;
            if (button !== 1'b0 || press_pulse !== 1'b0 || sel !== 1'b0 || dut_vec() !== exp_vec())
                $display("FAIL bounce cyc %0d: got %b want 00000", k, dut_vec());
            else n_pass++;
        end
    endtask

    task automatic test_short_press();
        int pa, sa, la, pc, sc, lc, df;
        run_press(8, 24, pa, sa, la, pc, sc, lc, df);
        n_checks++;
        if (df !== 0) $display("FAIL short_model: %0d cycles differ, want 0", df); else n_pass++;
        n_checks++;
        if (pa !== 6 || pc !== 1)
            $display("FAIL short_press_pulse: at %0d count %0d, want at 6 count 1", pa, pc);
        else n_pass++;
        n_checks++;
        if (sa !== 14 || sc !== 1 || lc !== 0)
            $display("FAIL short_pulse: at %0d count %0d long %0d, want at 14 count 1 long 0", sa, sc, lc);
        else n_pass++;
        n_checks++;
        if (sel !== 1'b0) $display("FAIL short_sel: got %b want 0", sel); else n_pass++;
    endtask

    task automatic test_long_press();
        int pa, sa, la, pc, sc, lc, df;
        run_press(30, 44, pa, sa, la, pc, sc, lc, df);
        n_checks++;
        if (df !== 0) $display("FAIL long_model: %0d cycles differ, want 0", df); else n_pass++;
        n_checks++;
        if (pa !== 6 || la !== 15 || lc !== 1 || sc !== 0)
            $display("FAIL long_timing: press %0d long %0d/%0d short %0d, want 6 15/1 0", pa, la, lc, sc);
        else n_pass++;
        n_checks++;
        if (sel !== 1'b1) $display("FAIL long_sel_first: got %b want 1", sel); else n_pass++;
        run_press(30, 44, pa, sa, la, pc, sc, lc, df);
        n_checks++;
        if (df !== 0 || lc !== 1 || sel !== 1'b0)
            $display("FAIL long_sel_second: diffs %0d long %0d sel %b, want 0 1 0", df, lc, sel);
        else n_pass++;
    endtask

    task automatic test_boundary();
        int pa, sa, la, pc, sc, lc, df;
        run_press(9, 24, pa, sa, la, pc, sc, lc, df);
        n_checks++;
        if (df !== 0 || sa !== 15 || sc !== 1 || lc !== 0 || sel !== 1'b0)
            $display("FAIL boundary_release_wins: diffs %0d short %0d/%0d long %0d sel %b, want 0 15/1 0 0",
                     df, sa, sc, lc, sel);
        else n_pass++;
        run_press(10, 24, pa, sa, la, pc, sc, lc, df);
        n_checks++;
        if (df !== 0 || la !== 15 || lc !== 1 || sc !== 0 || sel !== 1'b1)
            $display("FAIL boundary_long_wins: diffs %0d long %0d/%0d short %0d sel %b, want 0 15/1 0 1",
                     df, la, lc, sc, sel);
        else n_pass++;
    endtask

    task automatic test_reset_midpress();
        int pa, sa, la, pc, sc, lc, df;
        run_press(20, 32, pa, sa, la, pc, sc, lc, df);
        run_press(20, 20, pa, sa, la, pc, sc, lc, df);
        n_checks++;
        if (df !== 0 || la !== 15 || sel !== 1'b1)
            $display("FAIL midpress_held: diffs %0d long %0d sel %b, want 0 15 1", df, la, sel);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b1);
            n_checks++;
            if (dut_vec() !== 5'b0)
                $display("FAIL midpress_reset cyc %0d: got %b want 00000", k, dut_vec());
            else n_pass++;
        end
        run_press(0, 10, pa, sa, la, pc, sc, lc, df);
        n_checks++;
        if (df !== 0 || pc !== 0 || sc !== 0 || lc !== 0)
            $display("FAIL midpress_quiet: diffs %0d pulses %0d %0d %0d, want all 0", df, pc, sc, lc);
        else n_pass++;
        run_press(8, 24, pa, sa, la, pc, sc, lc, df);
        n_checks++;
        if (df !== 0 || pa !== 6 || pc !== 1 || sc !== 1 || sel !== 1'b0)
            $display("FAIL midpress_repress: diffs %0d press %0d/%0d short %0d sel %b, want 0 6/1 1 0",
                     df, pa, pc, sc, sel);
        else n_pass++;
    endtask

    task automatic test_random();
        logic lvl;
        int   left;
        int   errs;
        lvl  = 1'b0;
        left = 0;
        errs = 0;
        for (int k = 0; k < 2000; k++) begin
            logic r;
            if (left == 0) begin
                lvl  = ~lvl;
                left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20))
                                                   : int'($urandom_range(1, 6));
            end
            r = ($urandom_range(0, 299) == 0);
            tick(lvl, r);
            left--;
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL random cyc %0d: got %b want %b", k, dut_vec(), exp_vec());
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_short_press();
        test_long_press();
        test_boundary();
        test_reset_midpress();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
